// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receiver.
// FSM state encoding and the parity-type encoding shared with TX.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      OUT    = 3'd5
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter plus 3-sample majority voter.
// Ports: CLK/RST (sync, active-low), i_en run, i_prescale cycles/bit,
//   i_rx line; o_edge_cnt, o_bit_end, o_sampled_bit, o_sample_valid.
module uart_rx_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_prescale,
   input  logic                  i_rx,
   output logic [PRESCALE_W-1:0] o_edge_cnt,
   output logic                  o_bit_end,
   output logic                  o_sampled_bit,
   output logic                  o_sample_valid
);

   logic [PRESCALE_W-1:0] r_edge_cnt;
   logic [2:0]            r_smp;
   logic [PRESCALE_W-1:0] w_half;
   logic [PRESCALE_W-1:0] w_last;
   logic [PRESCALE_W-1:0] w_h_m1;
   logic [PRESCALE_W-1:0] w_h_p1;
   logic [PRESCALE_W-1:0] w_h_p2;

   assign w_half = i_prescale >> 1;
   assign w_last = i_prescale - PRESCALE_W'(1);
   assign w_h_m1 = w_half - PRESCALE_W'(1);
   assign w_h_p1 = w_half + PRESCALE_W'(1);
   assign w_h_p2 = w_half + PRESCALE_W'(2);

   assign o_edge_cnt     = r_edge_cnt;
   assign o_bit_end      = (r_edge_cnt == w_last);
   assign o_sample_valid = (r_edge_cnt >= w_h_p2);
   assign o_sampled_bit  = (r_smp[0] & r_smp[1]) |
                           (r_smp[0] & r_smp[2]) |
                           (r_smp[1] & r_smp[2]);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_edge_cnt <= '0;
         r_smp      <= '0;
      end else begin
         if (!i_en || o_bit_end)
            r_edge_cnt <= '0;
         else
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
         if (i_en) begin
            if (r_edge_cnt == w_h_m1) r_smp[0] <= i_rx;
            if (r_edge_cnt == w_half) r_smp[1] <= i_rx;
            if (r_edge_cnt == w_h_p1) r_smp[2] <= i_rx;
         end
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver FSM, LSB-first deserialiser, parity/stop check.
// Ports: CLK, RST (sync, active-low), RX_IN, PAR_EN, PAR_TYPE, Prescale;
//   P_DATA, Data_Valid, Par_Err, Stp_Err (registered one-cycle pulses).
import uart_rx_pkg::*;

module uart_rx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYPE,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   rx_state_t             r_state;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_p_data;
   logic                  r_par_en;
   logic                  r_par_type;
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_par_fail;
   logic                  r_data_valid;
   logic                  r_par_err;
   logic                  r_stp_err;

   logic                  w_idle_like;
   logic                  w_start;
   logic                  w_busy;
   logic                  w_glitch;
   logic                  w_en;
   logic [PRESCALE_W-1:0] w_presc;
   logic [PRESCALE_W-1:0] w_edge_cnt;
   logic                  w_bit_end;
   logic                  w_bit;
   logic                  w_sample_valid;
   logic                  w_par_exp;
   logic                  w_last_bit;

   // OUT behaves like IDLE for start detection (back-to-back frames);
   // the start-detect cycle itself is edge 0, so it runs on the live Prescale.
   assign w_idle_like = (r_state == IDLE) || (r_state == OUT);
   assign w_start     = w_idle_like && !RX_IN;
   assign w_presc     = w_idle_like ? Prescale : r_prescale;
   assign w_busy      = (r_state == START) || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);
   assign w_glitch    = (r_state == START) && w_sample_valid &&
                        w_bit && (w_edge_cnt != '0);
   assign w_en        = w_start || (w_busy && !w_glitch);
   assign w_par_exp   = (^r_shift) ^ (r_par_type == PAR_ODD);
   assign w_last_bit  = (r_bit_cnt == BW'(DATA_WIDTH - 1));

   uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
      .CLK            (CLK),
      .RST            (RST),
      .i_en           (w_en),
      .i_prescale     (w_presc),
      .i_rx           (RX_IN),
      .o_edge_cnt     (w_edge_cnt),
      .o_bit_end      (w_bit_end),
      .o_sampled_bit  (w_bit),
      .o_sample_valid (w_sample_valid)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_p_data     <= '0;
         r_par_en     <= 1'b0;
         r_par_type   <= 1'b0;
         r_prescale   <= '0;
         r_par_fail   <= 1'b0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         unique case (r_state)
            IDLE, OUT: begin
               if (w_start) begin
                  r_state    <= START;
                  r_par_en   <= PAR_EN;
                  r_par_type <= PAR_TYPE;
                  r_prescale <= Prescale;
                  r_par_fail <= 1'b0;
                  r_bit_cnt  <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            START: begin
               if (w_glitch)
                  r_state <= IDLE;
               else if (w_bit_end)
                  r_state <= DATA;
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                  if (w_last_bit) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? PARITY : STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (w_bit_end) begin
                  if (w_bit != w_par_exp) r_par_fail <= 1'b1;
                  r_state <= STOP;
               end
            end
            STOP: begin
               // Pulses are registered here so they appear during OUT.
               if (w_bit_end) begin
                  r_state      <= OUT;
                  r_data_valid <= !r_par_fail && w_bit;
                  r_par_err    <= r_par_fail;
                  r_stp_err    <= !w_bit;
                  if (!r_par_fail && w_bit) r_p_data <= r_shift;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign P_DATA     = r_p_data;
   assign Data_Valid = r_data_valid;
   assign Par_Err    = r_par_err;
   assign Stp_Err    = r_stp_err;

endmodule
